// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// HazardStallController
//
// Purpose:
//   Central pipeline hazard/stall controller for a classic 5-stage pipeline.
//   It resolves four kinds of events:
//     * data-memory back-pressure (memBusy), which freezes every stage
//     * multi-cycle multiply occupying EX for MUL_LAT cycles
//     * taken branches resolved in EX, which squash IF/ID and ID/EX
//     * load-use hazards, which insert a one-cycle bubble into ID/EX
//   It also keeps a saturating count of cycles in which the PC was frozen.
//
// Parameters:
//   MUL_LAT  total cycles a multiply occupies EX (2..15)
//   CNT_W    width of the stall-cycle statistics counter
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   IdExMemRead     instruction in EX is a load
//   IdExRegisterRt  load destination register in EX
//   IfIdRegisterRs  ID-stage source register A
//   IfIdRegisterRt  ID-stage source register B
//   IdExMulStart    a multiply is in EX
//   branchTaken     branch in EX resolved taken
//   memBusy         data memory cannot complete this cycle
//   statClear       synchronous clear of stallCount
//   pcWrite, ifIdWrite, idExWrite, exMemWrite   register-update enables
//   ifIdFlush, idExFlush, exMemFlush            bubble insertion controls
//   mulBusy         controller is in the multiply-wait state
//   stallCount      saturating count of cycles with pcWrite low
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IdExMemRead,
  input  logic [4:0]       IdExRegisterRt,
  input  logic [4:0]       IfIdRegisterRs,
  input  logic [4:0]       IfIdRegisterRt,
  input  logic             IdExMulStart,
  input  logic             branchTaken,
  input  logic             memBusy,
  input  logic             statClear,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExWrite,
  output logic             exMemWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             exMemFlush,
  output logic             mulBusy,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // The start cycle and the release cycle are both part of the MUL_LAT
  // occupancy, so the wait counter only has to cover the cycles in between.
  localparam logic [3:0] LP_MUL_RELOAD = 4'(MUL_LAT - 2);

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_evalState;
  logic [3:0]       r_mulCnt;
  logic [3:0]       w_nextMulCnt;
  logic             r_mulPend;
  logic             w_nextMulPend;
  logic [CNT_W-1:0] r_stallCount;

  logic w_loadUse;
  logic w_pcWrite;
  logic w_ifIdWrite;
  logic w_idExWrite;
  logic w_exMemWrite;
  logic w_ifIdFlush;
  logic w_idExFlush;
  logic w_exMemFlush;

  // A load in EX whose destination feeds either ID source; r0 is hardwired
  // zero and never creates a dependency.
  assign w_loadUse = IdExMemRead && (IdExRegisterRt != 5'd0) &&
                     ((IdExRegisterRt == IfIdRegisterRs) ||
                      (IdExRegisterRt == IfIdRegisterRt));

  // When memory frees up in MEM_WAIT, the same cycle is handled as if the
  // controller were already back in the state it was interrupted from.
  always_comb begin
    w_evalState = r_state;
    if ((r_state == MEM_WAIT) && !memBusy) begin
      w_evalState = r_mulPend ? MUL_WAIT : RUN;
    end
  end

  // Next-state and raw output decode. memBusy dominates in every state and
  // freezes mulCnt/mulPend; otherwise the evaluated state decides.
  always_comb begin
    w_nextState   = r_state;
    w_nextMulCnt  = r_mulCnt;
    w_nextMulPend = r_mulPend;
    w_pcWrite     = 1'b1;
    w_ifIdWrite   = 1'b1;
    w_idExWrite   = 1'b1;
    w_exMemWrite  = 1'b1;
    w_ifIdFlush   = 1'b0;
    w_idExFlush   = 1'b0;
    w_exMemFlush  = 1'b0;

    if (memBusy) begin
      w_pcWrite    = 1'b0;
      w_ifIdWrite  = 1'b0;
      w_idExWrite  = 1'b0;
      w_exMemWrite = 1'b0;
      w_nextState  = MEM_WAIT;
    end else begin
      case (w_evalState)
        RUN: begin
          w_nextState = RUN;
          if (IdExMulStart) begin
            w_pcWrite     = 1'b0;
            w_ifIdWrite   = 1'b0;
            w_idExWrite   = 1'b0;
            w_exMemFlush  = 1'b1;
            w_nextMulCnt  = LP_MUL_RELOAD;
            w_nextMulPend = 1'b1;
            w_nextState   = MUL_WAIT;
          end else if (branchTaken) begin
            w_ifIdFlush = 1'b1;
            w_idExFlush = 1'b1;
          end else if (w_loadUse) begin
            w_pcWrite   = 1'b0;
            w_ifIdWrite = 1'b0;
            w_idExFlush = 1'b1;
          end
        end

        MUL_WAIT: begin
          if (r_mulCnt != 4'd0) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExWrite  = 1'b0;
            w_exMemFlush = 1'b1;
            w_nextMulCnt = r_mulCnt - 4'd1;
            w_nextState  = MUL_WAIT;
          end else begin
            // Release cycle: the multiply is still in EX, so a new multiply
            // or branch cannot be acting here; only load-use matters.
            w_nextMulPend = 1'b0;
            w_nextState   = RUN;
            if (w_loadUse) begin
              w_pcWrite   = 1'b0;
              w_ifIdWrite = 1'b0;
              w_idExFlush = 1'b1;
            end
          end
        end

        default: begin
          w_nextState = RUN;
        end
      endcase
    end
  end

  // Controller state, multiply wait counter and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_mulCnt  <= 4'd0;
      r_mulPend <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_mulCnt  <= w_nextMulCnt;
      r_mulPend <= w_nextMulPend;
    end
  end

  // Saturating stall statistics; a clear request beats a pending increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCount <= '0;
    end else if (statClear) begin
      r_stallCount <= '0;
    end else if (!w_pcWrite && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  // Outputs are gated by rst_n so that every control goes low the moment
  // reset asserts, without waiting for a clock edge.
  assign pcWrite    = rst_n & w_pcWrite;
  assign ifIdWrite  = rst_n & w_ifIdWrite;
  assign idExWrite  = rst_n & w_idExWrite;
  assign exMemWrite = rst_n & w_exMemWrite;
  assign ifIdFlush  = rst_n & w_ifIdFlush;
  assign idExFlush  = rst_n & w_idExFlush;
  assign exMemFlush = rst_n & w_exMemFlush;
  assign mulBusy    = rst_n & (r_state == MUL_WAIT);
  assign stallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// TbHazardStallController
//
// Directed bench for hazard_stall_controller with MUL_LAT=4 and an 8-bit
// statistics counter so saturation is reachable quickly. Inputs change on
// the falling edge; outputs are sampled 1 time unit later.
// Output vector order: {pcWrite, ifIdWrite, idExWrite, exMemWrite,
//                       ifIdFlush, idExFlush, exMemFlush, mulBusy}
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 8;

  // Hand-built expected output patterns.
  localparam logic [7:0] EXP_RESET    = 8'b0000_0000;
  localparam logic [7:0] EXP_DEF      = 8'b1111_0000;
  localparam logic [7:0] EXP_LOADUSE  = 8'b0011_0100;
  localparam logic [7:0] EXP_BRANCH   = 8'b1111_1100;
  localparam logic [7:0] EXP_MULSTART = 8'b0001_0010;
  localparam logic [7:0] EXP_MULWAIT  = 8'b0001_0011;
  localparam logic [7:0] EXP_RELEASE  = 8'b1111_0001;
  localparam logic [7:0] EXP_RELLU    = 8'b0011_0101;
  localparam logic [7:0] EXP_MEMMUL   = 8'b0000_0001;
  localparam logic [7:0] EXP_MEM      = 8'b0000_0000;
  localparam logic [7:0] MASK_ALL     = 8'hFF;
  localparam logic [7:0] MASK_NOBUSY  = 8'hFE;

  logic             clk;
  logic             rst_n;
  logic             IdExMemRead;
  logic [4:0]       IdExRegisterRt;
  logic [4:0]       IfIdRegisterRs;
  logic [4:0]       IfIdRegisterRt;
  logic             IdExMulStart;
  logic             branchTaken;
  logic             memBusy;
  logic             statClear;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             idExWrite;
  logic             exMemWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             exMemFlush;
  logic             mulBusy;
  logic [CNT_W-1:0] stallCount;

  int testCount = 0;
  int failCount = 0;

  hazard_stall_controller #(
    .MUL_LAT(MUL_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IdExMemRead   (IdExMemRead),
    .IdExRegisterRt(IdExRegisterRt),
    .IfIdRegisterRs(IfIdRegisterRs),
    .IfIdRegisterRt(IfIdRegisterRt),
    .IdExMulStart  (IdExMulStart),
    .branchTaken   (branchTaken),
    .memBusy       (memBusy),
    .statClear     (statClear),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .idExWrite     (idExWrite),
    .exMemWrite    (exMemWrite),
    .ifIdFlush     (ifIdFlush),
    .idExFlush     (idExFlush),
    .exMemFlush    (exMemFlush),
    .mulBusy       (mulBusy),
    .stallCount    (stallCount)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's worth of inputs on the falling edge, then settle.
  task automatic applyStimulus(input logic memRead, input logic [4:0] exRt,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic mulStart, input logic branch,
                               input logic busy, input logic clr);
    @(negedge clk);
    IdExMemRead    = memRead;
    IdExRegisterRt = exRt;
    IfIdRegisterRs = rs;
    IfIdRegisterRt = rt;
    IdExMulStart   = mulStart;
    branchTaken    = branch;
    memBusy        = busy;
    statClear      = clr;
    #1;
  endtask

  // Compare the control vector (under a mask) against a hand-computed value.
  task automatic checkOutput(input string tag, input logic [7:0] expected,
                             input logic [7:0] mask);
    logic [7:0] observed;
    observed = {pcWrite, ifIdWrite, idExWrite, exMemWrite,
                ifIdFlush, idExFlush, exMemFlush, mulBusy};
    testCount++;
    assert ((observed & mask) === (expected & mask)) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%b expected=%b mask=%b",
             tag, observed, expected, mask);
    end
  endtask

  // Compare the statistics counter against a hand-computed value.
  task automatic checkCount(input string tag, input logic [CNT_W-1:0] expected);
    testCount++;
    assert (stallCount === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, stallCount, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    rst_n          = 1'b0;
    IdExMemRead    = 1'b0;
    IdExRegisterRt = 5'd0;
    IfIdRegisterRs = 5'd0;
    IfIdRegisterRt = 5'd0;
    IdExMulStart   = 1'b0;
    branchTaken    = 1'b0;
    memBusy        = 1'b0;
    statClear      = 1'b0;
    #1;
    checkOutput("reset_outputs", EXP_RESET, MASK_ALL);
    checkCount("reset_count", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle pipeline.
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_default", EXP_DEF, MASK_ALL);
    checkCount("idle_count", 8'd0);

    // Load-use on Rs, then r0 destination (no hazard), then load-use on Rt.
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_rs", EXP_LOADUSE, MASK_ALL);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_r0", EXP_DEF, MASK_ALL);
    checkCount("loaduse_count", 8'd1);
    applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_rt", EXP_LOADUSE, MASK_ALL);

    // Branch beats load-use.
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_over_loaduse", EXP_BRANCH, MASK_ALL);
    checkCount("branch_count", 8'd2);

    // Plain multiply: start, two wait cycles, release (branch/mul ignored).
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_start", EXP_MULSTART, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_wait1", EXP_MULWAIT, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_wait2", EXP_MULWAIT, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mul_release", EXP_RELEASE, MASK_ALL);
    checkCount("mul_release_count", 8'd5);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_after", EXP_DEF, MASK_ALL);
    checkCount("mul_total_count", 8'd5);

    // Multiply interrupted by 3 memBusy cycles; still 4 active cycles.
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mulmem_start", EXP_MULSTART, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mulmem_wait1", EXP_MULWAIT, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mulmem_busy1", EXP_MEMMUL, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mulmem_busy2", EXP_MEM, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mulmem_busy3", EXP_MEM, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mulmem_resume", EXP_MULSTART, MASK_NOBUSY);
    checkCount("mulmem_resume_count", 8'd10);
    applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mulmem_release_loaduse", EXP_RELLU, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mulmem_after", EXP_DEF, MASK_ALL);
    checkCount("mulmem_count", 8'd12);

    // Hold memBusy for 2^CNT_W+5 cycles to saturate, then clear.
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("membusy_long", EXP_MEM, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCount("saturated", 8'hFF);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCount("cleared", 8'd0);
    checkOutput("mem_release_run", EXP_DEF, MASK_ALL);

    // Reset asserted in the middle of a multiply wait.
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmul_start", EXP_MULSTART, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmul_wait", EXP_MULWAIT, MASK_ALL);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmul_in_reset", EXP_RESET, MASK_ALL);
    checkCount("rstmul_count", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmul_after1", EXP_DEF, MASK_ALL);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmul_after2", EXP_DEF, MASK_ALL);
    checkCount("rstmul_after_count", 8'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
- REQ-001 SHALL have parameter MUL_LAT, default 4, meaning total cycles a multi-cycle multiply occupies EX (legal range 2..15).
- REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall-cycle statistics counter.
- REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
- REQ-005 SHALL have port IdExMemRead, input, 1, meaning the instruction in EX is a load.
- REQ-006 SHALL have port IdExRegisterRt, input, 5, meaning the load destination in EX.
- REQ-007 SHALL have port IfIdRegisterRs, input, 5, meaning the ID-stage source register A.
- REQ-008 SHALL have port IfIdRegisterRt, input, 5, meaning the ID-stage source register B.
- REQ-009 SHALL have port IdExMulStart, input, 1, meaning a multiply is in EX.
- REQ-010 SHALL have port branchTaken, input, 1, meaning a branch resolved taken in EX.
- REQ-011 SHALL have port memBusy, input, 1, meaning data memory cannot complete this cycle.
- REQ-012 SHALL have port statClear, input, 1, meaning synchronous clear of stallCount.
- REQ-013 SHALL have outputs pcWrite, ifIdWrite, idExWrite, exMemWrite, each 1 bit, meaning register-update enables.
- REQ-014 SHALL have outputs ifIdFlush, idExFlush, exMemFlush, each 1 bit, meaning insert a bubble into that register.
- REQ-015 SHALL have output mulBusy, 1 bit, meaning state is MUL_WAIT.
- REQ-016 SHALL have output stallCount, CNT_W bits, meaning the saturating count of cycles with pcWrite=0.

Function
- REQ-017 SHALL define loadUse = IdExMemRead & (IdExRegisterRt!=0) & (IdExRegisterRt==IfIdRegisterRs | IdExRegisterRt==IfIdRegisterRt).
- REQ-018 SHALL implement states RUN, MUL_WAIT and MEM_WAIT, plus a 4-bit down-counter mulCnt and a flag mulPend.
- REQ-019 SHALL, by default (no event), drive all four write enables 1 and all flushes 0.
- REQ-020 SHALL apply this priority in RUN: memBusy, then IdExMulStart, then branchTaken, then loadUse.
- REQ-021 SHALL, on RUN with memBusy: drive all write enables 0 and flushes 0, go to MEM_WAIT, and leave mulPend unchanged.
- REQ-022 SHALL, on RUN with IdExMulStart: drive pcWrite, ifIdWrite and idExWrite to 0 and exMemFlush to 1, load mulCnt with MUL_LAT-2, set mulPend, and go to MUL_WAIT.
- REQ-023 SHALL, on RUN with branchTaken: drive ifIdFlush=1 and idExFlush=1, keep pcWrite=1, and stay in RUN.
- REQ-024 SHALL, on RUN with loadUse: drive pcWrite=0, ifIdWrite=0 and idExFlush=1, and stay in RUN (one-cycle combinational bubble).
- REQ-025 SHALL, in MUL_WAIT with mulCnt!=0 and no memBusy: drive outputs as in REQ-022 and decrement mulCnt.
- REQ-026 SHALL, in MUL_WAIT with mulCnt==0 and no memBusy (release cycle): drive default enables, clear mulPend, and go to RUN.
- REQ-027 SHALL apply loadUse per REQ-024 in the release cycle; it SHALL ignore branchTaken and IdExMulStart there.
- REQ-028 SHALL treat memBusy in MUL_WAIT as in REQ-021, with mulCnt frozen.
- REQ-029 SHALL, in MEM_WAIT, hold all enables 0, all flushes 0 and mulCnt frozen while memBusy=1.
- REQ-030 SHALL, when memBusy drops in MEM_WAIT, evaluate that same cycle as MUL_WAIT if mulPend=1, else as RUN.
- REQ-031 SHALL ensure an op started per REQ-022 occupies EX for exactly MUL_LAT non-memBusy cycles.
- REQ-032 SHALL increment stallCount each cycle pcWrite=0, saturate at all-ones, and let statClear win over increment.
- REQ-033 SHALL make all outputs except stallCount combinational from state and inputs, with no combinational path from outputs to inputs.

Reset
- REQ-034 SHALL, while rst_n=0, force state=RUN, mulCnt=0, mulPend=0, stallCount=0, all enables 0, all flushes 0, mulBusy=0.
- REQ-035 SHALL, on reset asserted mid-MUL_WAIT or mid-MEM_WAIT, discard the pending operation and restart in RUN with default outputs after release.

Verification
- REQ-036 SHALL cover: IdExMemRead=1, IdExRegisterRt=5, IfIdRegisterRs=5 -> one cycle pcWrite=0, idExFlush=1, stallCount=1; with IdExRegisterRt=0 -> no stall.
- REQ-037 SHALL cover: IdExMulStart pulse, MUL_LAT=4 -> 3 stall cycles with exMemFlush=1 and mulBusy=1 for 2 cycles, then the release cycle, then stallCount=3.
- REQ-038 SHALL cover: memBusy high 3 cycles in the middle of MUL_WAIT -> all enables 0 for 3 cycles, mulCnt frozen, multiply still spends 4 active cycles in EX.
- REQ-039 SHALL cover: branchTaken and loadUse together in RUN -> ifIdFlush=1, idExFlush=1, pcWrite=1.
- REQ-040 SHALL cover: pcWrite held at 0 for 2^CNT_W+5 cycles -> stallCount=all-ones; statClear that cycle -> 0 next cycle.
- REQ-041 SHALL cover: rst_n low mid-MUL_WAIT -> all outputs 0 immediately; after release, pcWrite=1, mulBusy=0.
